// File: rtl/alu_share_arbiter_if.sv
// Bundle between the two requesters, the shared ALU and the arbiter.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0, req1;
  logic [WIDTH-1:0] opA0, opB0, opA1, opB1;
  logic [2:0]       cmd0, cmd1;
  logic             gnt0, gnt1;

  logic [WIDTH-1:0] alu_operandA, alu_operandB;
  logic [2:0]       alu_command;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carryout, alu_zero, alu_overflow;

  logic             rsp_valid, rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carryout, rsp_zero, rsp_overflow;

  modport slave (
    input  req0, opA0, opB0, cmd0, req1, opA1, opB1, cmd1,
    output gnt0, gnt1,
    output alu_operandA, alu_operandB, alu_command,
    input  alu_result, alu_carryout, alu_zero, alu_overflow,
    output rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_zero, rsp_overflow
  );

  modport master (
    output req0, opA0, opB0, cmd0, req1, opA1, opB1, cmd1,
    input  gnt0, gnt1,
    input  alu_operandA, alu_operandB, alu_command,
    output alu_result, alu_carryout, alu_zero, alu_overflow,
    input  rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_zero, rsp_overflow
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters: latch the
// winner's operands, hold them for SETTLE cycles, capture and return a tagged response.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_share_arbiter_if.slave   bus
);
  localparam int NUM_PORTS = 2;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       cmd;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             ovf;
    logic             id;
  } rsp_t;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic                   cur_id_q, cur_id_d;
  req_t                   issue_q, issue_d;
  rsp_t                   rsp_q, rsp_d;

  logic [NUM_PORTS-1:0]   req, gnt;
  req_t [NUM_PORTS-1:0]   req_in;
  logic                   win_id;

  assign req       = {bus.req1, bus.req0};
  assign req_in[0] = '{op_a: bus.opA0, op_b: bus.opB0, cmd: bus.cmd0};
  assign req_in[1] = '{op_a: bus.opA1, op_b: bus.opB1, cmd: bus.cmd1};

  // On a tie the port that was not served last wins.
  always_comb begin
    gnt = '0;
    if (state_q == IDLE) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  assign win_id = gnt[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    cur_id_d = cur_id_q;
    issue_d  = issue_q;
    rsp_d    = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          issue_d  = req_in[win_id];
          cur_id_d = win_id;
          cnt_d    = CNT_INIT;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_d   = '{result: bus.alu_result, carry: bus.alu_carryout,
                      zero: bus.alu_zero, ovf: bus.alu_overflow, id: cur_id_q};
          last_d  = cur_id_q;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      cur_id_q <= 1'b0;
      issue_q  <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      cur_id_q <= cur_id_d;
      issue_q  <= issue_d;
      rsp_q    <= rsp_d;
    end
  end

  assign bus.gnt0         = gnt[0];
  assign bus.gnt1         = gnt[1];
  assign bus.alu_operandA = issue_q.op_a;
  assign bus.alu_operandB = issue_q.op_b;
  assign bus.alu_command  = issue_q.cmd;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_id       = rsp_q.id;
  assign bus.rsp_result   = rsp_q.result;
  assign bus.rsp_carryout = rsp_q.carry;
  assign bus.rsp_zero     = rsp_q.zero;
  assign bus.rsp_overflow = rsp_q.ovf;

endmodule
